// File: rtl/dma_pkg.sv
// Shared DMA definitions: engine state encoding and default bus widths.
// Used by the memory reader and by the planned UART-RX-to-memory writer.
package dma_pkg;

   localparam int unsigned DMA_DATA_WIDTH = 8;
   localparam int unsigned DMA_ADDR_WIDTH = 8;
   localparam int unsigned DMA_LEN_W      = DMA_ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      SEND,
      DONE
   } dma_state_t;

endpackage

// File: rtl/memory_module.sv
// Simple dual-port byte memory: synchronous write port, registered read port.
// data_out only updates on a read enable, so it holds its value between reads.
module memory_module #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned MEMORY_DEPTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[write_address] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
      end else if (re) begin
         data_out <= mem[read_address];
      end
   end

endmodule

// File: rtl/dma_mem_reader.sv
// DMA read engine: fetches a contiguous block of bytes from memory and hands
// them one at a time to the UART transmitter over a valid/ready interface.
module dma_mem_reader
   import dma_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DMA_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DMA_ADDR_WIDTH,
   parameter int unsigned MEMORY_DEPTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   sent_count,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready
);

   dma_state_t            state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  abort_flag;
   logic                  abort_hit;

   // The current abort pulse counts as well as the sticky flag, so an abort
   // seen in FETCH or CAPTURE takes effect on that same edge.
   assign abort_hit = abort | abort_flag;
   assign next_addr = (cur_addr == ADDR_WIDTH'(MEMORY_DEPTH - 1)) ? '0 : cur_addr + 1'b1;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cur_addr         <= '0;
         remaining        <= '0;
         sent_count       <= '0;
         mem_read_address <= '0;
         mem_re           <= 1'b0;
         tx_data          <= '0;
         tx_valid         <= 1'b0;
         abort_flag       <= 1'b0;
      end else begin
         if (state != IDLE && abort) begin
            abort_flag <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  sent_count <= '0;
                  abort_flag <= 1'b0;
                  if (length != '0) begin
                     cur_addr         <= src_addr;
                     remaining        <= length;
                     mem_read_address <= src_addr;
                     mem_re           <= 1'b1;
                     state            <= FETCH;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            FETCH: begin
               mem_re <= 1'b0;
               state  <= abort_hit ? DONE : CAPTURE;
            end
            CAPTURE: begin
               if (abort_hit) begin
                  state <= DONE;
               end else begin
                  tx_data  <= mem_data_out;
                  tx_valid <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               // tx_valid is never withdrawn here; abort waits for the handshake.
               if (tx_ready) begin
                  tx_valid   <= 1'b0;
                  sent_count <= sent_count + 1'b1;
                  remaining  <= remaining - 1'b1;
                  cur_addr   <= next_addr;
                  if (remaining == (ADDR_WIDTH + 1)'(1) || abort_hit) begin
                     state <= DONE;
                  end else begin
                     mem_read_address <= next_addr;
                     mem_re           <= 1'b1;
                     state            <= FETCH;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
